// File: rtl/connect_count_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : connect_count_accumulator
// Description : Collects results from the connected-component counting core.
//               Each valid result adds 2^connectCount into a wide run sum.
//               The block also counts results and XOR-folds the job tags.
//               When the expected number of results has arrived, it pulses
//               runFinished and holds the totals.
// Revision    : 1.0 - initial release
// ============================================================================
module connect_count_accumulator #(
    parameter int EXTRA_DATA_WIDTH = 10,
    parameter int SUM_WIDTH        = 80,
    parameter int COUNT_WIDTH      = 36
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        runStart,
    input  logic [COUNT_WIDTH-1:0]      expectedResults,
    input  logic                        done,
    input  logic [5:0]                  connectCount,
    input  logic [EXTRA_DATA_WIDTH-1:0] extraData,
    output logic [SUM_WIDTH-1:0]        sum,
    output logic [COUNT_WIDTH-1:0]      resultsSeen,
    output logic [EXTRA_DATA_WIDTH-1:0] tagChecksum,
    output logic                        runFinished,
    output logic                        busy,
    output logic                        overflow,
    output logic                        strayResult
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCUM    = 2'd1,
        S_FINISHED = 2'd2
    } state_t;

    localparam logic [SUM_WIDTH-1:0]   c_one      = {{(SUM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] c_seen_max = {COUNT_WIDTH{1'b1}};

    state_t                      r_state_q,    w_state_d;
    logic [COUNT_WIDTH-1:0]      r_expected_q, w_expected_d;
    logic                        r_started_q,  w_started_d;

    logic                        r_s1_valid_q, w_s1_valid_d;
    logic [5:0]                  r_s1_count_q, w_s1_count_d;
    logic [EXTRA_DATA_WIDTH-1:0] r_s1_tag_q,   w_s1_tag_d;

    logic                        r_s2_valid_q, w_s2_valid_d;
    logic [SUM_WIDTH-1:0]        r_s2_value_q, w_s2_value_d;
    logic [EXTRA_DATA_WIDTH-1:0] r_s2_tag_q,   w_s2_tag_d;

    logic [SUM_WIDTH-1:0]        r_sum_q,      w_sum_d;
    logic [COUNT_WIDTH-1:0]      r_seen_q,     w_seen_d;
    logic [EXTRA_DATA_WIDTH-1:0] r_tag_q,      w_tag_d;
    logic                        r_finished_q, w_finished_d;
    logic                        r_overflow_q, w_overflow_d;
    logic                        r_stray_q,    w_stray_d;

    logic                        w_in_flight;
    logic                        w_finish;
    logic                        w_accept;
    logic                        w_carry;
    logic [SUM_WIDTH-1:0]        w_sum_add;

    // Next-state, pipeline and accumulator update logic
    always_comb begin
        w_state_d    = r_state_q;
        w_expected_d = r_expected_q;
        w_started_d  = 1'b0;
        w_s1_valid_d = 1'b0;
        w_s1_count_d = connectCount;
        w_s1_tag_d   = extraData;
        w_s2_valid_d = 1'b0;
        w_s2_value_d = c_one << r_s1_count_q;
        w_s2_tag_d   = r_s1_tag_q;
        w_sum_d      = r_sum_q;
        w_seen_d     = r_seen_q;
        w_tag_d      = r_tag_q;
        w_finished_d = 1'b0;
        w_overflow_d = r_overflow_q;
        w_stray_d    = r_stray_q;

        w_in_flight = r_s1_valid_q | r_s2_valid_q;
        // The started flag holds off completion for the first ACCUM cycle,
        // so an empty run finishes two cycles after its start.
        w_finish    = (r_state_q == S_ACCUM) && !r_started_q &&
                      (r_seen_q >= r_expected_q) && !w_in_flight;
        // A result arriving on the completion edge belongs to no run.
        w_accept    = done && (runStart || ((r_state_q == S_ACCUM) && !w_finish));
        {w_carry, w_sum_add} = {1'b0, r_sum_q} + {1'b0, r_s2_value_q};

        if (runStart) begin
            w_state_d    = S_ACCUM;
            w_expected_d = expectedResults;
            w_started_d  = 1'b1;
            w_s1_valid_d = done;
            w_sum_d      = '0;
            w_seen_d     = '0;
            w_tag_d      = '0;
            w_overflow_d = 1'b0;
            w_stray_d    = 1'b0;
        end else begin
            w_s1_valid_d = w_accept;
            w_s2_valid_d = r_s1_valid_q;

            if (r_s2_valid_q) begin
                w_sum_d = w_sum_add;
                w_tag_d = r_tag_q ^ r_s2_tag_q;
                if (w_carry) begin
                    w_overflow_d = 1'b1;
                end
                if (r_seen_q != c_seen_max) begin
                    w_seen_d = r_seen_q + 1'b1;
                end
                if (r_seen_q >= r_expected_q) begin
                    w_stray_d = 1'b1;
                end
            end

            if (done && !w_accept) begin
                w_stray_d = 1'b1;
            end

            if (w_finish) begin
                w_state_d    = S_FINISHED;
                w_finished_d = 1'b1;
            end
        end
    end

    // State, pipeline and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= S_IDLE;
            r_expected_q <= '0;
            r_started_q  <= 1'b0;
            r_s1_valid_q <= 1'b0;
            r_s1_count_q <= '0;
            r_s1_tag_q   <= '0;
            r_s2_valid_q <= 1'b0;
            r_s2_value_q <= '0;
            r_s2_tag_q   <= '0;
            r_sum_q      <= '0;
            r_seen_q     <= '0;
            r_tag_q      <= '0;
            r_finished_q <= 1'b0;
            r_overflow_q <= 1'b0;
            r_stray_q    <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_expected_q <= w_expected_d;
            r_started_q  <= w_started_d;
            r_s1_valid_q <= w_s1_valid_d;
            r_s1_count_q <= w_s1_count_d;
            r_s1_tag_q   <= w_s1_tag_d;
            r_s2_valid_q <= w_s2_valid_d;
            r_s2_value_q <= w_s2_value_d;
            r_s2_tag_q   <= w_s2_tag_d;
            r_sum_q      <= w_sum_d;
            r_seen_q     <= w_seen_d;
            r_tag_q      <= w_tag_d;
            r_finished_q <= w_finished_d;
            r_overflow_q <= w_overflow_d;
            r_stray_q    <= w_stray_d;
        end
    end

    assign sum         = r_sum_q;
    assign resultsSeen = r_seen_q;
    assign tagChecksum = r_tag_q;
    assign runFinished = r_finished_q;
    assign busy        = (r_state_q == S_ACCUM);
    assign overflow    = r_overflow_q;
    assign strayResult = r_stray_q;

endmodule
`default_nettype wire

// File: tb/tb_connect_count_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_connect_count_accumulator
// Description : Bench for connect_count_accumulator. Two instances (80-bit
//               and 64-bit sum) share the stimulus; expected totals come
//               from a wide arithmetic model of each run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_connect_count_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        runStart = 1'b0;
    logic [35:0] expectedResults = '0;
    logic        done = 1'b0;
    logic [5:0]  connectCount = '0;
    logic [9:0]  extraData = '0;

    logic [79:0] sum80;
    logic [35:0] seen80;
    logic [9:0]  tag80;
    logic        rf80, busy80, ov80, stray80;
    logic [63:0] sum64;
    logic [35:0] seen64;
    logic [9:0]  tag64;
    logic        rf64, busy64, ov64, stray64;

    int n_checks = 0;
    int n_fail   = 0;
    int rf_cnt   = 0;

    int         cnt_a [16];
    logic [9:0] tag_a [16];

    always #5 clk = ~clk;

    connect_count_accumulator u80 (
        .clk(clk), .rst(rst), .runStart(runStart), .expectedResults(expectedResults),
        .done(done), .connectCount(connectCount), .extraData(extraData),
        .sum(sum80), .resultsSeen(seen80), .tagChecksum(tag80), .runFinished(rf80),
        .busy(busy80), .overflow(ov80), .strayResult(stray80)
    );

    connect_count_accumulator #(.SUM_WIDTH(64)) u64 (
        .clk(clk), .rst(rst), .runStart(runStart), .expectedResults(expectedResults),
        .done(done), .connectCount(connectCount), .extraData(extraData),
        .sum(sum64), .resultsSeen(seen64), .tagChecksum(tag64), .runFinished(rf64),
        .busy(busy64), .overflow(ov64), .strayResult(stray64)
    );

    // Count runFinished cycles seen on the 80-bit instance
    always @(negedge clk) begin
        if (rf80) rf_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++;
        if ({sum80, seen80, tag80, rf80, busy80, ov80, stray80} !== '0) begin
            n_fail++;
            $display("FAIL reset80: got sum=%h seen=%0d tag=%h rf=%b busy=%b ov=%b stray=%b, want all 0",
                     sum80, seen80, tag80, rf80, busy80, ov80, stray80);
        end
        n_checks++;
        if ({sum64, seen64, tag64, rf64, busy64, ov64, stray64} !== '0) begin
            n_fail++;
            $display("FAIL reset64: got sum=%h seen=%0d rf=%b busy=%b, want all 0", sum64, seen64, rf64, busy64);
        end
    endtask

    // Drive one run of n results from cnt_a/tag_a and check totals and timing
    task automatic run_results(input int e, input int n, input bit gaps, input string name);
        logic [127:0] tsum;
        logic [9:0]   tx;
        logic [79:0]  exp80;
        logic [63:0]  exp64;
        logic         eov80, eov64, estray;
        tsum = '0;
        tx   = '0;
        for (int i = 0; i < n; i++) begin
            tsum = tsum + (128'd1 << cnt_a[i]);
            tx   = tx ^ tag_a[i];
        end
        exp80  = tsum[79:0];
        exp64  = tsum[63:0];
        eov80  = (tsum >> 80) != 0;
        eov64  = (tsum >> 64) != 0;
        estray = n > e;

        runStart = 1'b1;
        expectedResults = 36'(e);
        step();
        runStart = 1'b0;
        rf_cnt = 0;
        if (n == 0) begin
            step();
            n_checks++;
            if (rf80 !== 1'b0 || busy80 !== 1'b1) begin
                n_fail++;
                $display("FAIL %s early_finish: rf=%b busy=%b, want rf=0 busy=1", name, rf80, busy80);
            end
            step();
        end else begin
            for (int i = 0; i < n; i++) begin
                done = 1'b1;
                connectCount = 6'(cnt_a[i]);
                extraData = tag_a[i];
                step();
                done = 1'b0;
                if (gaps && i < n - 1) repeat ($urandom_range(0, 3)) step();
            end
            step();
            step();
            n_checks++;
            if (sum80 !== exp80 || seen80 !== 36'(n) || tag80 !== tx || ov80 !== eov80 || stray80 !== estray) begin
                n_fail++;
                $display("FAIL %s totals80: got sum=%h seen=%0d tag=%h ov=%b stray=%b, want sum=%h seen=%0d tag=%h ov=%b stray=%b",
                         name, sum80, seen80, tag80, ov80, stray80, exp80, n, tx, eov80, estray);
            end
            n_checks++;
            if (sum64 !== exp64 || ov64 !== eov64) begin
                n_fail++;
                $display("FAIL %s totals64: got sum=%h ov=%b, want sum=%h ov=%b", name, sum64, ov64, exp64, eov64);
            end
            n_checks++;
            if (rf80 !== 1'b0) begin
                n_fail++;
                $display("FAIL %s early_finish: rf=%b at t+2, want 0", name, rf80);
            end
            step();
        end
        n_checks++;
        if (rf80 !== 1'b1 || rf64 !== 1'b1 || busy80 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s finish_pulse: rf80=%b rf64=%b busy=%b, want rf=1 busy=0", name, rf80, rf64, busy80);
        end
        step();
        step();
        n_checks++;
        if (rf80 !== 1'b0 || rf_cnt !== 1 || sum80 !== exp80 || seen80 !== 36'(n)) begin
            n_fail++;
            $display("FAIL %s hold: rf=%b pulses=%0d sum=%h seen=%0d, want rf=0 pulses=1 sum=%h seen=%0d",
                     name, rf80, rf_cnt, sum80, seen80, exp80, n);
        end
    endtask

    task automatic test_back_to_back();
        cnt_a[0] = 0; tag_a[0] = 10'h001;
        cnt_a[1] = 1; tag_a[1] = 10'h002;
        cnt_a[2] = 5; tag_a[2] = 10'h004;
        run_results(3, 3, 1'b0, "b2b");
        n_checks++;
        if (sum80 !== 80'd35 || tag80 !== 10'h007) begin
            n_fail++;
            $display("FAIL b2b_values: got sum=%0d tag=%h, want sum=35 tag=007", sum80, tag80);
        end
    endtask

    task automatic test_max_count();
        cnt_a[0] = 63; tag_a[0] = 10'h155;
        run_results(1, 1, 1'b0, "max63");
    endtask

    task automatic test_overflow();
        cnt_a[0] = 63; tag_a[0] = 10'h0F0;
        cnt_a[1] = 63; tag_a[1] = 10'h00F;
        run_results(2, 2, 1'b0, "ovf");
        n_checks++;
        if (sum64 !== 64'd0 || ov64 !== 1'b1 || ov80 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_flag: got sum64=%h ov64=%b ov80=%b, want 0 1 0", sum64, ov64, ov80);
        end
    endtask

    task automatic test_extra_results();
        cnt_a[0] = 2; tag_a[0] = 10'h011;
        cnt_a[1] = 3; tag_a[1] = 10'h022;
        run_results(1, 2, 1'b0, "extra");
    endtask

    task automatic test_zero_expected();
        run_results(0, 0, 1'b0, "zero");
        done = 1'b1;
        connectCount = 6'd3;
        extraData = 10'h3FF;
        step();
        done = 1'b0;
        repeat (3) step();
        n_checks++;
        if (stray80 !== 1'b1 || sum80 !== 80'd0 || seen80 !== 36'd0 || rf_cnt !== 1) begin
            n_fail++;
            $display("FAIL zero_stray: got stray=%b sum=%h seen=%0d pulses=%0d, want 1 0 0 1",
                     stray80, sum80, seen80, rf_cnt);
        end
    endtask

    task automatic test_restart_in_flight();
        runStart = 1'b1;
        expectedResults = 36'd4;
        step();
        runStart = 1'b0;
        done = 1'b1; connectCount = 6'd7; extraData = 10'h3FF;
        step();
        runStart = 1'b1; expectedResults = 36'd2;
        done = 1'b1; connectCount = 6'd4; extraData = 10'h011;
        step();
        runStart = 1'b0;
        done = 1'b0;
        rf_cnt = 0;
        step();
        step();
        n_checks++;
        if (sum80 !== 80'd16 || seen80 !== 36'd1 || tag80 !== 10'h011 || busy80 !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_partial: got sum=%0d seen=%0d tag=%h busy=%b, want 16 1 011 1",
                     sum80, seen80, tag80, busy80);
        end
        done = 1'b1; connectCount = 6'd0; extraData = 10'h020;
        step();
        done = 1'b0;
        step();
        step();
        n_checks++;
        if (sum80 !== 80'd17 || seen80 !== 36'd2 || tag80 !== 10'h031 || rf80 !== 1'b0 || rf_cnt !== 0) begin
            n_fail++;
            $display("FAIL restart_totals: got sum=%0d seen=%0d tag=%h rf=%b pulses=%0d, want 17 2 031 0 0",
                     sum80, seen80, tag80, rf80, rf_cnt);
        end
        step();
        n_checks++;
        if (rf80 !== 1'b1 || stray80 !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_finish: got rf=%b stray=%b, want 1 0", rf80, stray80);
        end
    endtask

    task automatic test_mid_reset();
        runStart = 1'b1;
        expectedResults = 36'd4;
        step();
        runStart = 1'b0;
        done = 1'b1; connectCount = 6'd2; extraData = 10'h00A;
        step();
        done = 1'b0;
        step();
        step();
        n_checks++;
        if (sum80 !== 80'd4 || seen80 !== 36'd1) begin
            n_fail++;
            $display("FAIL midrst_pre: got sum=%0d seen=%0d, want 4 1", sum80, seen80);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        rf_cnt = 0;
        n_checks++;
        if ({sum80, seen80, tag80, rf80, busy80, ov80, stray80} !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear: got sum=%h seen=%0d tag=%h rf=%b busy=%b, want all 0",
                     sum80, seen80, tag80, rf80, busy80);
        end
        repeat (5) step();
        n_checks++;
        if (rf_cnt !== 0 || busy80 !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: got pulses=%0d busy=%b, want 0 0", rf_cnt, busy80);
        end
    endtask

    task automatic test_random();
        int e;
        for (int r = 0; r < 20; r++) begin
            e = $urandom_range(1, 6);
            for (int i = 0; i < 8; i++) begin
                cnt_a[i] = $urandom_range(0, 63);
                tag_a[i] = 10'($urandom);
            end
            if (r % 4 == 3) run_results(e, e + 1, 1'b0, "rand_extra");
            else            run_results(e, e, 1'b1, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_max_count();
        test_overflow();
        test_extra_results();
        test_zero_expected();
        test_restart_in_flight();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/connect_count_accumulator.md
# connect_count_accumulator

Downstream consumer of the pipelined connected-component counting core. Each cycle the core asserts `done`, this block takes the returned `connectCount` and adds 2^connectCount into a wide run sum. It also counts results and folds every returned `extraData` into an XOR checksum. When the expected number of results for a run has arrived, it signals completion and holds the final totals for the host-side reader.

## Interface
Parameters:
- EXTRA_DATA_WIDTH, 10, width of the job tag returned by the core
- SUM_WIDTH, 80, width of the 2^count accumulator; must be ≥ 64
- COUNT_WIDTH, 36, width of the expected/seen result counters

Ports:
- clk  input  1  single clock
- rst  input  1  synchronous, active-high reset
- runStart  input  1  one-cycle pulse: begin a new run
- expectedResults  input  COUNT_WIDTH  number of results in the run; sampled on `runStart`
- done  input  1  core result valid
- connectCount  input  6  component count of the result
- extraData  input  EXTRA_DATA_WIDTH  job tag of the result
- sum  output  SUM_WIDTH  running Σ 2^connectCount
- resultsSeen  output  COUNT_WIDTH  results accumulated this run
- tagChecksum  output  EXTRA_DATA_WIDTH  XOR of all accepted tags
- runFinished  output  1  one-cycle pulse when the run completes
- busy  output  1  high in ACCUM
- overflow  output  1  sticky: `sum` carried out of SUM_WIDTH
- strayResult  output  1  sticky: `done` seen outside ACCUM

## Operation
- States: IDLE, ACCUM, FINISHED. Reset state is IDLE.
- `runStart`, from any state:
  - Go to ACCUM and latch `expectedResults`.
  - Clear `sum`, `resultsSeen`, `tagChecksum`, `overflow` and `strayResult`.
  - Flush both pipeline stages.
- Stage 1 registers `done`, `connectCount` and `extraData`, qualified by state == ACCUM.
- Stage 2 decodes the one-hot value 1 << connectCount, zero-extended to SUM_WIDTH.
- Update, applied when stage 2 holds a valid result:
  - `sum` += value.
  - `resultsSeen` += 1.
  - `tagChecksum` ^= tag.
  - A carry out of `sum` sets `overflow`; `sum` wraps modulo 2^SUM_WIDTH.
- Completion:
  - In ACCUM, when `resultsSeen` == latched expected and no valid entry is in flight, go to FINISHED.
  - Assert `runFinished` for exactly that one transition cycle.
  - `expectedResults` = 0 finishes 2 cycles after `runStart`.
- In FINISHED and IDLE: all outputs hold their values.
- Stray results:
  - `done` in IDLE or FINISHED sets `strayResult` and is not accumulated.
  - Results in ACCUM beyond the expected count are accumulated and also set `strayResult`; the run still finishes only once.
- `resultsSeen` saturates at all-ones and never wraps.
- `connectCount` covers the full 0–63 range; 2^63 must fit, hence SUM_WIDTH ≥ 64.

## Timing
- Reset values:
  - `sum`, `resultsSeen`, `tagChecksum` = 0.
  - `runFinished`, `busy`, `overflow`, `strayResult` = 0.
  - Pipeline valids = 0.
- Latency: `done` at edge t is visible in `sum`/`resultsSeen` after edge t+2.
- `runFinished` asserts no earlier than the edge after the final update (t+3).
- Throughput: one result per cycle, no backpressure. `done` may be high on consecutive cycles.
- `runStart` and `done` in the same cycle: the `done` is sampled with the new run's qualifier and counts toward the new run. Entries from the old run still in stage 1/2 are discarded.
- `rst` mid-run: next cycle, everything is at reset values and the state is IDLE. No `runFinished` is generated.
- `runStart` while FINISHED: `runFinished` is not re-asserted, and the totals clear on the next edge.

## Test plan
- Reset, then `runStart` with expected=3; `done` ×3 back-to-back with counts 0, 1, 5 and tags 0x001, 0x002, 0x004:
  - `sum`=35, `resultsSeen`=3, `tagChecksum`=0x007.
  - One `runFinished` pulse at t+3 after the last `done`.
- Expected=1 with count 63: `sum`=0x8000000000000000, `overflow`=0.
- SUM_WIDTH=64, expected=2, counts 63 and 63:
  - `sum`=0, `overflow`=1, `runFinished` pulses.
- Expected=0: `runFinished` 2 cycles after `runStart`, `sum`=0. A later `done` sets `strayResult`=1 and leaves `sum` unchanged.
- `runStart` (expected=2) coincident with a `done` (count 4) while an old-run result is in flight:
  - Only the count-4 result is accumulated.
  - `resultsSeen`=1; run finishes after one more `done`.
- Mid-run reset after 1 of 4 results: all outputs go to 0 next cycle; no `runFinished`, and `busy`=0.
